// File: rtl/tangent_divider_if.sv
// Stream bundle between the CORDIC core, the tangent divider and the timing stage.
// Handshake: cordic_valid_i is a one-cycle strobe with no ready; a tan_o word transfers on any
// rising clock edge where tan_valid_o & tan_ready_i, and tan_valid_o/tan_o hold until then.
interface tangent_divider_if;
   logic        cordic_valid_i;
   logic [15:0] cordic_cos_i;
   logic [15:0] cordic_sin_i;
   logic        tan_valid_o;
   logic        tan_ready_i;
   logic [15:0] tan_o;

   modport slave (
      input  cordic_valid_i, cordic_cos_i, cordic_sin_i, tan_ready_i,
      output tan_valid_o, tan_o
   );

   modport master (
      output cordic_valid_i, cordic_cos_i, cordic_sin_i, tan_ready_i,
      input  tan_valid_o, tan_o
   );
endinterface

// File: rtl/tangent_divider.sv
// tan = sin/cos for CORDIC Q1.14 pairs: input FIFO, one-bit-per-cycle restoring divider,
// saturation to +-0x7FFF and a registered valid/ready output.
module tangent_divider #(
   parameter int FRAC_BITS  = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk_i,
   input  logic                nrst_i,
   tangent_divider_if.slave    bus,
   output logic                busy_o,
   output logic                overflow_o,
   output logic [2:0]          state_o
);

   localparam int DIV_W = 16 + FRAC_BITS;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(DIV_W);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIN  = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
   logic             overflow_q;
   logic [15:0]      sin_q, cos_q;
   logic [16:0]      sin_abs_q, cos_abs_q;
   logic             neg_q, zero_q;
   logic [DIV_W-1:0] dvd_q, quot_q;
   logic [16:0]      rem_q;
   logic [CNT_W-1:0] cnt_q;
   logic [15:0]      tan_q;
   logic             tan_valid_q;

   logic             empty, full, push, pop;
   logic [31:0]      head;
   logic [16:0]      sin_ext, cos_ext, sin_abs, cos_abs;
   logic [17:0]      trial;
   logic             trial_ge;
   logic [14:0]      mag;
   logic [15:0]      result;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop   = (state_q == S_IDLE) && !empty;
   assign push  = bus.cordic_valid_i && (!full || pop);
   assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.cordic_sin_i, bus.cordic_cos_i};
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (bus.cordic_valid_i && !push) overflow_q <= 1'b1;
      end
   end

   // 17-bit magnitudes so that -32768 becomes +32768 without wrapping.
   assign sin_ext = {sin_q[15], sin_q};
   assign cos_ext = {cos_q[15], cos_q};
   assign sin_abs = sin_q[15] ? (17'd0 - sin_ext) : sin_ext;
   assign cos_abs = cos_q[15] ? (17'd0 - cos_ext) : cos_ext;

   assign trial    = {rem_q, dvd_q[DIV_W-1]} - {1'b0, cos_abs_q};
   assign trial_ge = !trial[17];

   always_comb begin
      mag = 15'd0;
      if (zero_q)                 mag = (sin_abs_q == 17'd0) ? 15'd0 : 15'h7FFF;
      else if (|quot_q[DIV_W-1:15]) mag = 15'h7FFF;
      else                        mag = quot_q[14:0];
      result = neg_q ? (16'd0 - {1'b0, mag}) : {1'b0, mag};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (!empty) state_d = S_LOAD;
         S_LOAD: state_d = (cos_abs == 17'd0) ? S_FIN : S_DIV;
         S_DIV:  if (cnt_q == '0) state_d = S_FIN;
         S_FIN:  state_d = S_OUT;
         S_OUT:  if (bus.tan_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q     <= S_IDLE;
         sin_q       <= '0;
         cos_q       <= '0;
         sin_abs_q   <= '0;
         cos_abs_q   <= '0;
         neg_q       <= 1'b0;
         zero_q      <= 1'b0;
         dvd_q       <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         tan_q       <= '0;
         tan_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (pop) {sin_q, cos_q} <= head;
            S_LOAD: begin
               neg_q     <= sin_q[15] ^ cos_q[15];
               sin_abs_q <= sin_abs;
               cos_abs_q <= cos_abs;
               zero_q    <= (cos_abs == 17'd0);
               dvd_q     <= {sin_abs[15:0], {FRAC_BITS{1'b0}}};
               quot_q    <= '0;
               rem_q     <= '0;
               cnt_q     <= CNT_W'(DIV_W - 1);
            end
            S_DIV: begin
               rem_q  <= trial_ge ? trial[16:0] : {rem_q[15:0], dvd_q[DIV_W-1]};
               quot_q <= {quot_q[DIV_W-2:0], trial_ge};
               dvd_q  <= {dvd_q[DIV_W-2:0], 1'b0};
               cnt_q  <= cnt_q - 1'b1;
            end
            S_FIN: begin
               tan_q       <= result;
               tan_valid_q <= 1'b1;
            end
            S_OUT: if (bus.tan_ready_i) tan_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.tan_o       = tan_q;
   assign bus.tan_valid_o = tan_valid_q;
   assign busy_o          = (state_q != S_IDLE) || !empty;
   assign overflow_o      = overflow_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_tangent_divider.sv
// Self-checking bench for tangent_divider: directed vector table, burst/backpressure/reset
// sequences and a randomized stream scored against an arithmetic reference model.
module tb_tangent_divider;

   localparam int FRAC_BITS  = 12;
   localparam int FIFO_DEPTH = 4;
   localparam int DIV_W      = 16 + FRAC_BITS;

   logic       clk;
   logic       nrst;
   logic       busy;
   logic       overflow;
   logic [2:0] state;

   tangent_divider_if bus();

   tangent_divider #(.FRAC_BITS(FRAC_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_i      (clk),
      .nrst_i     (nrst),
      .bus        (bus),
      .busy_o     (busy),
      .overflow_o (overflow),
      .state_o    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [15:0] sin;
      logic [15:0] cos;
      logic [15:0] tan;
      int          lat;
   } vec_t;

   vec_t vecs[9];

   // Reference: real quotient of magnitudes scaled by 2^FRAC_BITS, truncated, saturated.
   function automatic logic [15:0] model_tan(logic [15:0] s, logic [15:0] c);
      longint sv, cv, as, ac, mag;
      logic   neg;
      sv  = longint'($signed(s));
      cv  = longint'($signed(c));
      as  = (sv < 0) ? -sv : sv;
      ac  = (cv < 0) ? -cv : cv;
      neg = (sv < 0) != (cv < 0);
      if (ac == 0) mag = (as == 0) ? 0 : 32767;
      else begin
         mag = (as * (longint'(1) << FRAC_BITS)) / ac;
         if (mag > 32767) mag = 32767;
      end
      return neg ? 16'(-mag) : 16'(mag);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(logic [15:0] s, logic [15:0] c);
      bus.cordic_valid_i = 1'b1;
      bus.cordic_sin_i   = s;
      bus.cordic_cos_i   = c;
      step();
      bus.cordic_valid_i = 1'b0;
   endtask

   task automatic wait_valid(int max, output int cyc);
      cyc = 0;
      while (!bus.tan_valid_o && cyc < max) begin
         step();
         cyc++;
      end
   endtask

   task automatic accept();
      bus.tan_ready_i = 1'b1;
      step();
      bus.tan_ready_i = 1'b0;
   endtask

   initial begin
      int          lat, cnt, bad, hold, low_run, gap, sent, got, cycles;
      logic [15:0] s, c, held;
      logic [15:0] bs[6];
      logic [15:0] bc[6];

      vecs[0] = '{16'h2000, 16'h2000, 16'h1000, 31};
      vecs[1] = '{16'h1000, 16'h4000, 16'h0400, 31};
      vecs[2] = '{16'hF000, 16'h4000, 16'hFC00, 31};
      vecs[3] = '{16'h1000, 16'hC000, 16'hFC00, 31};
      vecs[4] = '{16'h2000, 16'h0000, 16'h7FFF, 3};
      vecs[5] = '{16'hE000, 16'h0000, 16'h8001, 3};
      vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 3};
      vecs[7] = '{16'h4000, 16'h0010, 16'h7FFF, 31};
      vecs[8] = '{16'h8000, 16'h4000, 16'hE000, 31};  // -32768/16384 = -2.0

      nrst = 1'b0;
      bus.cordic_valid_i = 1'b0;
      bus.cordic_sin_i   = '0;
      bus.cordic_cos_i   = '0;
      bus.tan_ready_i    = 1'b0;
      repeat (3) step();
      check("rst_tan_valid", 32'(bus.tan_valid_o), 0);
      check("rst_tan", 32'(bus.tan_o), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_state_idle", 32'(state), 0);
      nrst = 1'b1;
      step();

      // Directed vectors, one at a time, ready only raised after valid.
      for (int i = 0; i < 9; i++) begin
         push(vecs[i].sin, vecs[i].cos);
         wait_valid(200, lat);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_tan", i), 32'(bus.tan_o), 32'(vecs[i].tan));
         accept();
         check($sformatf("vec%0d_valid_clear", i), 32'(bus.tan_valid_o), 0);
      end

      // Burst of six with the output stalled: five kept, sixth dropped.
      for (int i = 0; i < 6; i++) begin
         bs[i] = 16'($urandom);
         bc[i] = 16'($urandom);
      end
      bus.cordic_valid_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.cordic_sin_i = bs[i];
         bus.cordic_cos_i = bc[i];
         step();
      end
      bus.cordic_valid_i = 1'b0;
      check("burst_overflow", 32'(overflow), 1);
      for (int i = 0; i < 5; i++) begin
         wait_valid(200, lat);
         check($sformatf("burst%0d_valid", i), 32'(bus.tan_valid_o), 1);
         check($sformatf("burst%0d_tan", i), 32'(bus.tan_o), 32'(model_tan(bs[i], bc[i])));
         held = bus.tan_o;
         bad  = 0;
         hold = $urandom_range(1, 6);
         repeat (hold) begin
            step();
            if (!bus.tan_valid_o || bus.tan_o !== held) bad++;
         end
         check($sformatf("burst%0d_held", i), 32'(bad), 0);
         accept();
      end
      cnt = 0;
      repeat (60) begin
         step();
         if (bus.tan_valid_o) cnt++;
      end
      check("burst_no_sixth", 32'(cnt), 0);
      check("burst_idle_busy", 32'(busy), 0);

      // Long backpressure, then the next queued result arrives DIV_W+4 cycles after accept.
      push(16'h1800, 16'h3000);
      push(16'hD000, 16'h2000);
      wait_valid(200, lat);
      check("bp_tan", 32'(bus.tan_o), 32'(model_tan(16'h1800, 16'h3000)));
      held = bus.tan_o;
      bad  = 0;
      repeat (100) begin
         step();
         if (!bus.tan_valid_o || bus.tan_o !== held) bad++;
      end
      check("bp_stable_100", 32'(bad), 0);
      bus.tan_ready_i = 1'b1;
      step();
      bus.tan_ready_i = 1'b0;
      cnt = 1;
      while (!bus.tan_valid_o && cnt < 200) begin
         step();
         cnt++;
      end
      check("bp_next_interval", 32'(cnt), 32'(DIV_W + 4));
      check("bp_next_tan", 32'(bus.tan_o), 32'(model_tan(16'hD000, 16'h2000)));
      accept();

      // Reset in the middle of a division with two entries still queued.
      push(16'h1234, 16'h2345);
      push(16'h0F00, 16'h0100);
      push(16'hF100, 16'h0200);
      repeat (8) step();
      check("mid_busy", 32'(busy), 1);
      check("mid_overflow_sticky", 32'(overflow), 1);
      #2 nrst = 1'b0;
      #1;
      check("mid_rst_tan_valid", 32'(bus.tan_valid_o), 0);
      check("mid_rst_tan", 32'(bus.tan_o), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_overflow", 32'(overflow), 0);
      step();
      #3 nrst = 1'b1;
      bus.tan_ready_i = 1'b1;
      cnt = 0;
      repeat (100) begin
         step();
         if (bus.tan_valid_o) cnt++;
      end
      bus.tan_ready_i = 1'b0;
      check("post_rst_no_stale", 32'(cnt), 0);
      check("post_rst_busy", 32'(busy), 0);

      // Randomized stream with random (bounded) backpressure.
      sent = 0;
      got = 0;
      gap = 0;
      low_run = 0;
      cycles = 0;
      while ((sent < 40 || exp_q.size() != 0) && cycles < 20000) begin
         bus.cordic_valid_i = 1'b0;
         if (sent < 40 && gap == 0) begin
            case ($urandom_range(0, 3))
               0: begin s = 16'($urandom); c = 16'($urandom); end
               1: begin s = 16'($urandom); c = 16'($urandom_range(0, 40)); end
               2: begin s = 16'($urandom); c = 16'h0000; end
               default: begin s = 16'($urandom_range(0, 4095)); c = 16'($urandom) | 16'h2000; end
            endcase
            bus.cordic_valid_i = 1'b1;
            bus.cordic_sin_i   = s;
            bus.cordic_cos_i   = c;
            exp_q.push_back(model_tan(s, c));
            sent++;
            gap = $urandom_range(DIV_W + 8, DIV_W + 30);
         end else if (gap > 0) begin
            gap--;
         end
         bus.tan_ready_i = (low_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
         low_run = bus.tan_ready_i ? 0 : low_run + 1;
         if (bus.tan_valid_o && bus.tan_ready_i) begin
            if (exp_q.size() == 0) check("rand_unexpected", 32'(bus.tan_o), 0);
            else check($sformatf("rand%0d_tan", got), 32'(bus.tan_o), 32'(exp_q.pop_front()));
            got++;
         end
         step();
         cycles++;
      end
      bus.cordic_valid_i = 1'b0;
      bus.tan_ready_i    = 1'b0;
      check("rand_result_count", 32'(got), 40);
      check("rand_no_overflow", 32'(overflow), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
